fpu_round_pack: RTL and testbench
=================================

# fpu_round_pack

Result packer and rounder for the single-precision FPU datapath. It is the output-side counterpart of the operand unpack stage. The unpack stage splits packed IEEE 754 words into sign, exponent and mantissa with the hidden bit. This block takes an unnormalized sign/exponent/extended-mantissa result and normalizes it iteratively, one bit per cycle. It then rounds per `mode_in`, packs the 32-bit word and raises the exception flags. Valid/ready handshakes on both sides.

## Interface
- `EXP_W`, default 10: width of the signed biased input exponent (two's complement).
- `COLLAPSE`, default 26: if the exponent is below `1-COLLAPSE`, the mantissa collapses to sticky in one step.
- `clk_in` in 1: clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode_in` in 2: rounding mode. 00 = nearest-even, 01 = toward zero, 10 = toward +inf, 11 = toward -inf. Sampled at accept.
- `in_valid` in 1: input result valid.
- `in_ready` out 1: block can accept a result; high only in IDLE.
- `in_sign` in 1: result sign.
- `in_exp` in EXP_W: signed biased exponent of mantissa bit 26.
- `in_mant` in 28: mantissa bit fields.
  - bit 27: carry.
  - bit 26: integer.
  - bits 25:3: fraction.
  - bit 2: guard.
  - bit 1: round.
  - bit 0: sticky.
- `in_nan` in 1: result is NaN; overrides all other inputs.
- `in_inf` in 1: result is infinity; overrides mantissa and exponent.
- `out_valid` out 1: packed result valid.
- `out_ready` in 1: downstream accepts the result.
- `out` out 32: packed IEEE 754 word.
- `overflow`, `underflow`, `in_exact`, `zero`, `op_nan` out 1 each: exception flags, valid with `out_valid`.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE → NORM on `in_valid && in_ready`. This captures sign, exponent, mantissa, special flags and mode.
- NORM performs exactly one action per cycle, in the priority order below. Steps 3–5 shift right; the bit shifted out ORs into sticky (bit 0).
  1. `in_nan`/`in_inf` captured → ROUND.
  2. mant == 0 → ROUND (zero result).
  3. mant[27] = 1 → shift right 1, exp += 1.
  4. exp < 1−COLLAPSE → mant = {27'b0, |mant}, exp = 1.
  5. exp < 1 → shift right 1, exp += 1.
  6. mant[26] = 0 and exp > 1 → shift left 1, exp −= 1.
  7. Otherwise → ROUND.
- ROUND: one cycle. It registers `out` and the flags, sets `out_valid`, and moves to DONE.
  - Rounding inputs: lsb = mant[3], g = mant[2], rs = mant[1] | mant[0].
  - inc = mode 00: g & (rs | lsb); 01: 0; 10: ~sign & (g | rs); 11: sign & (g | rs).
  - m25 = mant[26:3] + inc. If m25[24] = 1: m25 >>= 1, exp += 1.
  - Exponent field = exp when m25[23] = 1, else 0 (subnormal or zero). A subnormal that rounds up into bit 23 packs with field 1.
- Exponent ≥ 255 after rounding:
  - `overflow` = 1 and `in_exact` = 1.
  - Mode 00 → ±inf.
  - Mode 01 → ±0x7F7FFFFF.
  - Mode 10 → +inf when positive, otherwise −max.
  - Mode 11 → −inf when negative, otherwise +max.
- Flag rules:
  - `in_exact` = g | rs, or overflow.
  - `underflow` = exponent field 0 and `in_exact`.
  - `zero` = packed magnitude 0.
- Special results:
  - NaN → `out` = 0x7FC00000, `op_nan` = 1, other flags 0.
  - Inf → {sign, 8'hFF, 23'b0}, all flags 0.
  - Zero mantissa → {sign, 31'b0}, `zero` = 1.
- DONE: `out` and the flags are held stable while `out_valid` = 1. On `out_ready` = 1 → IDLE, `out_valid` = 0.

## Timing
- Reset values:
  - State IDLE, so `in_ready` = 1.
  - `out_valid` = 0, `out` = 0.
  - All flags 0.
- `rst` in any state aborts the operation in flight. The next cycle is IDLE with the reset values and can accept immediately.
- Latency: with k NORM shift/collapse steps, `out_valid` rises at the (2 + k)th rising edge after the accepting edge. Minimum is 2, for a normalized or special input.
- One result in flight; no new input is accepted until the DONE → IDLE handoff completes.
- Throughput for back-to-back normalized inputs with `out_ready` held at 1: one result per 4 cycles.
- `out_ready` low holds DONE indefinitely with no change to any output.
- `mode_in` changes after accept do not affect the result in flight.

## Test plan
- Normalized input: exp = 127, mant = 28'h4000000, mode 00 → `out` = 0x3F800000, flags 0, `out_valid` at edge 2.
- Cancellation: exp = 127, mant = 28'h0000008 → 23 left shifts, `out` = 0x34000000, `out_valid` at edge 25.
- Rounding: exp = 127, mant = 28'h4000004 (exact tie).
  - Mode 00 → 0x3F800000, `in_exact` = 1.
  - Mode 10 → 0x3F800001.
  - Mode 01 → 0x3F800000.
- Overflow: exp = 254, mant = 28'hFFFFFFF.
  - Mode 00 → 0x7F800000, `overflow` = 1, `in_exact` = 1.
  - Mode 01 → 0x7F7FFFFF.
- Underflow: exp = −200, mant = 28'h4000000, mode 10 → collapse, `out` = 0x00000001, `underflow` = 1.
- Specials and handshake:
  - `in_nan` → 0x7FC00000, `op_nan` = 1.
  - `out_ready` held low 5 cycles → output stable, `in_ready` = 0.
  - `rst` during NORM → next cycle `in_ready` = 1, `out_valid` = 0.

Source files
------------

// File: rtl/fpu_round_pack_if.sv
// Handshake and data bundle between the FPU result producer and the round/pack stage.
// The master drives results in and accepts packed words; the slave is the packer itself.
interface fpu_round_pack_if #(
    parameter int unsigned EXP_W = 10
);
    logic [1:0]       mode_in;
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [27:0]      in_mant;
    logic             in_nan;
    logic             in_inf;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out;
    logic             overflow;
    logic             underflow;
    logic             in_exact;
    logic             zero;
    logic             op_nan;

    modport master (
        output mode_in, in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
        input  in_ready, out_valid, out, overflow, underflow, in_exact, zero, op_nan
    );

    modport slave (
        input  mode_in, in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
        output in_ready, out_valid, out, overflow, underflow, in_exact, zero, op_nan
    );
endinterface

// File: rtl/fpu_round_pack.sv
// Normalizes an unnormalized FPU result one bit per cycle, rounds it per the captured
// rounding mode and packs it into an IEEE 754 single-precision word with exception flags.
module fpu_round_pack #(
    parameter int unsigned EXP_W    = 10,
    parameter int unsigned COLLAPSE = 26
) (
    input logic            clk_in,
    input logic            rst,
    fpu_round_pack_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    localparam logic signed [EXP_W-1:0] ExpOne      = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] ExpCollapse = EXP_W'(1 - int'(COLLAPSE));
    localparam logic signed [EXP_W-1:0] ExpMax      = EXP_W'(255);

    state_e                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [27:0]             mant_q, mant_d;
    logic                    nan_q, nan_d;
    logic                    inf_q, inf_d;
    logic [1:0]              mode_q, mode_d;
    logic                    valid_q, valid_d;
    logic [31:0]             out_q, out_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    inx_q, inx_d;
    logic                    zero_q, zero_d;
    logic                    opnan_q, opnan_d;

    // Rounding datapath, evaluated from the normalized state.
    logic                    lsb, grd, rs, inc, inf_sel;
    logic [24:0]             m25;
    logic [23:0]             m24;
    logic signed [EXP_W-1:0] exp_r;
    logic                    rnd_ovf, rnd_inx;
    logic [7:0]              field;
    logic [31:0]             rnd_out;
    logic [27:0]             mant_shr;

    assign mant_shr = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};

    always_comb begin
        lsb = mant_q[3];
        grd = mant_q[2];
        rs  = mant_q[1] | mant_q[0];
        unique case (mode_q)
            2'b00:   inc = grd & (rs | lsb);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~sign_q & (grd | rs);
            2'b11:   inc = sign_q & (grd | rs);
            default: inc = 1'b0;
        endcase
        m25 = {1'b0, mant_q[26:3]} + {24'b0, inc};
        if (m25[24]) begin
            m24   = m25[24:1];
            exp_r = exp_q + ExpOne;
        end else begin
            m24   = m25[23:0];
            exp_r = exp_q;
        end
        rnd_ovf = (exp_r >= ExpMax);
        rnd_inx = grd | rs | rnd_ovf;
        // Subnormals sit at exp 1, so a carry into bit 23 packs with field 1.
        field   = m24[23] ? exp_r[7:0] : 8'h00;
        inf_sel = (mode_q == 2'b00) | ((mode_q == 2'b10) & ~sign_q) |
                  ((mode_q == 2'b11) & sign_q);
        if (rnd_ovf) begin
            rnd_out = inf_sel ? {sign_q, 8'hFF, 23'h000000} : {sign_q, 8'hFE, 23'h7FFFFF};
        end else begin
            rnd_out = {sign_q, field, m24[22:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;
        zero_d  = zero_q;
        opnan_d = opnan_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    exp_d   = $signed(bus.in_exp);
                    mant_d  = bus.in_mant;
                    nan_d   = bus.in_nan;
                    inf_d   = bus.in_inf;
                    mode_d  = bus.mode_in;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (nan_q || inf_q || (mant_q == 28'd0)) begin
                    state_d = StRound;
                end else if (mant_q[27]) begin
                    mant_d = mant_shr;
                    exp_d  = exp_q + ExpOne;
                end else if (exp_q < ExpCollapse) begin
                    // Far below the subnormal range: every bit ends up in sticky anyway.
                    mant_d = {27'b0, |mant_q};
                    exp_d  = ExpOne;
                end else if (exp_q < ExpOne) begin
                    mant_d = mant_shr;
                    exp_d  = exp_q + ExpOne;
                end else if (!mant_q[26] && (exp_q > ExpOne)) begin
                    mant_d = {mant_q[26:0], 1'b0};
                    exp_d  = exp_q - ExpOne;
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                valid_d = 1'b1;
                state_d = StDone;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                inx_d   = 1'b0;
                zero_d  = 1'b0;
                opnan_d = 1'b0;
                if (nan_q) begin
                    out_d   = 32'h7FC00000;
                    opnan_d = 1'b1;
                end else if (inf_q) begin
                    out_d = {sign_q, 8'hFF, 23'h000000};
                end else begin
                    out_d  = rnd_out;
                    ovf_d  = rnd_ovf;
                    inx_d  = rnd_inx;
                    unf_d  = ~rnd_ovf & (field == 8'h00) & rnd_inx;
                    zero_d = (rnd_out[30:0] == 31'd0);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            mode_q  <= 2'b00;
            valid_q <= 1'b0;
            out_q   <= 32'h0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
            zero_q  <= 1'b0;
            opnan_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
            zero_q  <= zero_d;
            opnan_q <= opnan_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = valid_q;
    assign bus.out       = out_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.in_exact  = inx_q;
    assign bus.zero      = zero_q;
    assign bus.op_nan    = opnan_q;

endmodule

// File: tb/tb_fpu_round_pack.sv
// Directed-vector bench for fpu_round_pack: hand-computed packed words, flags and latencies,
// plus output hold under back-pressure and reset abort during normalization.
module tb_fpu_round_pack;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    fpu_round_pack_if #(.EXP_W(10)) bus ();

    fpu_round_pack #(.EXP_W(10), .COLLAPSE(26)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [4:0] flags;
    assign flags = {bus.overflow, bus.underflow, bus.in_exact, bus.zero, bus.op_nan};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Flags order: {overflow, underflow, in_exact, zero, op_nan}.
    task automatic run_vec(input string tag, input logic s, input logic [9:0] e,
                           input logic [27:0] m, input logic nan, input logic inf,
                           input logic [1:0] md, input logic [31:0] want_out,
                           input logic [4:0] want_flags, input int want_lat, input int hold);
        int lat;
        bus.in_sign   = s;
        bus.in_exp    = e;
        bus.in_mant   = m;
        bus.in_nan    = nan;
        bus.in_inf    = inf;
        bus.mode_in   = md;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk_in);
        #1;
        bus.in_valid = 1'b0;
        bus.mode_in  = ~md;  // must not affect the result in flight
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk_in);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(want_lat));
        check_eq({tag, "_out"}, bus.out, want_out);
        check_eq({tag, "_flg"}, 32'(flags), 32'(want_flags));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk_in);
            #1;
            check_eq({tag, "_hold_out"}, bus.out, want_out);
            check_eq({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk_in);
        #1;
        check_eq({tag, "_idle_vld"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_nan    = 1'b0;
        bus.in_inf    = 1'b0;
        bus.mode_in   = 2'b00;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst = 1'b0;
        check_eq("rst_rdy", 32'(bus.in_ready), 32'd1);
        check_eq("rst_vld", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out", bus.out, 32'h0);
        check_eq("rst_flg", 32'(flags), 32'd0);

        run_vec("norm",    0, 10'd127, 28'h4000000, 0, 0, 2'b00, 32'h3F800000, 5'b00000, 2, 0);
        run_vec("cancel",  0, 10'd127, 28'h0000008, 0, 0, 2'b00, 32'h34000000, 5'b00000, 25, 0);
        run_vec("tie_rne", 0, 10'd127, 28'h4000004, 0, 0, 2'b00, 32'h3F800000, 5'b00100, 2, 0);
        run_vec("tie_rup", 0, 10'd127, 28'h4000004, 0, 0, 2'b10, 32'h3F800001, 5'b00100, 2, 0);
        run_vec("tie_rtz", 0, 10'd127, 28'h4000004, 0, 0, 2'b01, 32'h3F800000, 5'b00100, 2, 0);
        run_vec("tie_rdn", 1, 10'd127, 28'h4000004, 0, 0, 2'b11, 32'hBF800001, 5'b00100, 2, 0);
        run_vec("rne_carry", 0, 10'd127, 28'h7FFFFFC, 0, 0, 2'b00, 32'h40000000, 5'b00100, 2, 0);
        run_vec("ovf_rne", 0, 10'd254, 28'hFFFFFFF, 0, 0, 2'b00, 32'h7F800000, 5'b10100, 3, 0);
        run_vec("ovf_rtz", 0, 10'd254, 28'hFFFFFFF, 0, 0, 2'b01, 32'h7F7FFFFF, 5'b10100, 3, 0);
        run_vec("ovf_neg_rup", 1, 10'd254, 28'hFFFFFFF, 0, 0, 2'b10, 32'hFF7FFFFF, 5'b10100, 3, 0);
        run_vec("unf_collapse", 0, 10'h338, 28'h4000000, 0, 0, 2'b10, 32'h00000001, 5'b01100, 3,
                0);
        run_vec("subnorm", 0, 10'd0, 28'h4000000, 0, 0, 2'b00, 32'h00400000, 5'b00000, 3, 0);
        run_vec("sub_to_norm", 0, 10'd0, 28'h7FFFFFF, 0, 0, 2'b00, 32'h00800000, 5'b00100, 3, 0);
        run_vec("nan",     0, 10'd5,   28'h1234567, 1, 0, 2'b00, 32'h7FC00000, 5'b00001, 2, 0);
        run_vec("inf_neg", 1, 10'd5,   28'h1234567, 0, 1, 2'b00, 32'hFF800000, 5'b00000, 2, 0);
        run_vec("zero_neg", 1, 10'd50, 28'h0000000, 0, 0, 2'b00, 32'h80000000, 5'b00010, 2, 0);
        run_vec("hold",    0, 10'd127, 28'h4000000, 0, 0, 2'b00, 32'h3F800000, 5'b00000, 2, 5);

        // Abort a long normalization with reset.
        bus.in_sign  = 1'b0;
        bus.in_exp   = 10'd127;
        bus.in_mant  = 28'h0000008;
        bus.in_valid = 1'b1;
        @(posedge clk_in);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        check_eq("abort_rdy", 32'(bus.in_ready), 32'd1);
        check_eq("abort_vld", 32'(bus.out_valid), 32'd0);
        check_eq("abort_out", bus.out, 32'h0);
        run_vec("after_abort", 0, 10'd128, 28'h6000000, 0, 0, 2'b00, 32'h40400000, 5'b00000, 2,
                0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
